// File: rtl/timer_scheduler.sv
// Four-channel tick-based one-shot timers sharing a single prescaler time base.
// Outputs register one clock after the causing edge; there is no backpressure and inputs are sampled every clock.
module timer_scheduler #(
    parameter int CLK_HZ  = 50000000,
    parameter int TICK_HZ = 1000,
    parameter int DUR_W   = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [3:0]         start,
    input  logic [4*DUR_W-1:0] duration,
    input  logic [3:0]         cancel,
    input  logic [1:0]         remaining_sel,
    output logic               tick,
    output logic [3:0]         busy,
    output logic [3:0]         done,
    output logic [DUR_W-1:0]   remaining
);

    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int PW  = (DIV > 2) ? $clog2(DIV) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    logic [PW-1:0]    presc_q;
    state_t           state_q [4];
    state_t           state_d [4];
    logic [DUR_W-1:0] rem_q   [4];
    logic [DUR_W-1:0] rem_d   [4];
    logic [3:0]       done_d;

    // Tick is registered off the terminal count, so it lands one clock after DIV-1.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            presc_q <= '0;
            tick    <= 1'b0;
        end else if (presc_q == PW'(DIV - 1)) begin
            presc_q <= '0;
            tick    <= 1'b1;
        end else begin
            presc_q <= presc_q + PW'(1);
            tick    <= 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                state_q[i] <= IDLE;
                rem_q[i]   <= '0;
            end
            done <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                state_q[i] <= state_d[i];
                rem_q[i]   <= rem_d[i];
            end
            done <= done_d;
        end
    end

    // Priority per channel: cancel, then start/restart, then tick countdown.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            state_d[i] = state_q[i];
            rem_d[i]   = rem_q[i];
            done_d[i]  = 1'b0;
            if (cancel[i]) begin
                state_d[i] = IDLE;
                rem_d[i]   = '0;
            end else if (start[i]) begin
                if (duration[i*DUR_W +: DUR_W] == '0) begin
                    state_d[i] = IDLE;
                    rem_d[i]   = '0;
                    done_d[i]  = 1'b1;
                end else begin
                    state_d[i] = RUN;
                    rem_d[i]   = duration[i*DUR_W +: DUR_W];
                end
            end else if (state_q[i] == RUN && tick) begin
                if (rem_q[i] == DUR_W'(1)) begin
                    state_d[i] = IDLE;
                    rem_d[i]   = '0;
                    done_d[i]  = 1'b1;
                end else begin
                    rem_d[i] = rem_q[i] - DUR_W'(1);
                end
            end
        end
    end

    always_comb begin
        busy = '0;
        for (int i = 0; i < 4; i++) begin
            busy[i] = (state_q[i] == RUN);
        end
    end

    assign remaining = rem_q[remaining_sel];

endmodule

// File: tb/tb_timer_scheduler.sv
// Randomized and directed stimulus against a cycle-level reference model; a monitor checks every clock.
module tb_timer_scheduler;

    localparam int DUR_W = 16;
    localparam int DIV   = 10;

    logic               clock = 1'b0;
    logic               reset = 1'b1;
    logic [3:0]         start = '0;
    logic [3:0]         cancel = '0;
    logic [4*DUR_W-1:0] duration = '0;
    logic [1:0]         remaining_sel = '0;
    logic               tick;
    logic [3:0]         busy;
    logic [3:0]         done;
    logic [DUR_W-1:0]   remaining;

    timer_scheduler #(
        .CLK_HZ (1000),
        .TICK_HZ(100),
        .DUR_W  (DUR_W)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .duration     (duration),
        .cancel       (cancel),
        .remaining_sel(remaining_sel),
        .tick         (tick),
        .busy         (busy),
        .done         (done),
        .remaining    (remaining)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic             t;
        logic [3:0]       b;
        logic [3:0]       d;
        logic [DUR_W-1:0] r;
        int               cyc;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   m_cnt;
    logic m_tick;
    int   left[4];
    int   cyc_no;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s at t=%0t: got=%0d expected=%0d", name, $time, act, expv);
        end
    endtask

    task automatic model_reset();
        m_cnt  = 0;
        m_tick = 1'b0;
        for (int i = 0; i < 4; i++) left[i] = 0;
        cyc_no = 0;
    endtask

    // Advance the model across the next rising edge using the inputs now applied.
    task automatic cycle();
        exp_t       e;
        logic [3:0] dn;
        logic [3:0] bz;
        dn = '0;
        bz = '0;
        for (int ch = 0; ch < 4; ch++) begin
            int dur;
            dur = int'(duration[ch*DUR_W +: DUR_W]);
            if (cancel[ch]) begin
                left[ch] = 0;
            end else if (start[ch]) begin
                if (dur == 0) begin
                    left[ch] = 0;
                    dn[ch]   = 1'b1;
                end else begin
                    left[ch] = dur;
                end
            end else if (left[ch] > 0 && m_tick) begin
                left[ch] = left[ch] - 1;
                if (left[ch] == 0) dn[ch] = 1'b1;
            end
            bz[ch] = (left[ch] != 0);
        end
        m_cnt  = m_cnt + 1;
        m_tick = (m_cnt % DIV == 0);
        e.t    = m_tick;
        e.b    = bz;
        e.d    = dn;
        e.r    = DUR_W'(left[remaining_sel]);
        e.cyc  = cyc_no;
        cyc_no = cyc_no + 1;
        q.push_back(e);
        @(negedge clock);
    endtask

    task automatic idle(input int n);
        start  = '0;
        cancel = '0;
        repeat (n) cycle();
    endtask

    task automatic set_dur(input int ch, input int dur);
        duration[ch*DUR_W +: DUR_W] = DUR_W'(dur);
    endtask

    task automatic pulse(input logic [3:0] st, input logic [3:0] cn);
        start  = st;
        cancel = cn;
        cycle();
        start  = '0;
        cancel = '0;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk($sformatf("tick c%0d", e.cyc), 32'(tick), 32'(e.t));
                chk($sformatf("busy c%0d", e.cyc), 32'(busy), 32'(e.b));
                chk($sformatf("done c%0d", e.cyc), 32'(done), 32'(e.d));
                chk($sformatf("remaining c%0d", e.cyc), 32'(remaining), 32'(e.r));
            end
        end
    end

    initial begin : stim
        #1;
        chk("rst tick", 32'(tick), 0);
        chk("rst busy", 32'(busy), 0);
        chk("rst done", 32'(done), 0);
        chk("rst remaining", 32'(remaining), 0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        model_reset();

        // Free-running ticks with nothing started.
        idle(25);

        // Channel 0, duration 3.
        remaining_sel = 2'd0;
        set_dur(0, 3);
        pulse(4'b0001, 4'b0000);
        idle(35);

        // Channel 1: duration 5, then restart with 2 after two ticks.
        remaining_sel = 2'd1;
        set_dur(1, 5);
        pulse(4'b0010, 4'b0000);
        for (int k = 0; k < 100 && left[1] != 3; k++) idle(1);
        chk("ch1 rem before restart", 32'(remaining), 3);
        set_dur(1, 2);
        pulse(4'b0010, 4'b0000);
        idle(30);

        // Channel 2: cancel at rem=4, then start+cancel together in IDLE.
        remaining_sel = 2'd2;
        set_dur(2, 6);
        pulse(4'b0100, 4'b0000);
        for (int k = 0; k < 100 && left[2] != 4; k++) idle(1);
        chk("ch2 rem before cancel", 32'(remaining), 4);
        pulse(4'b0000, 4'b0100);
        idle(3);
        set_dur(2, 5);
        pulse(4'b0100, 4'b0100);
        idle(15);

        // Channels 0 and 3 together, then a zero-duration start.
        remaining_sel = 2'd3;
        set_dur(0, 2);
        set_dur(3, 2);
        pulse(4'b1001, 4'b0000);
        idle(30);
        set_dur(1, 0);
        pulse(4'b0010, 4'b0000);
        idle(3);

        // Asynchronous reset in the middle of a run, away from any rising edge.
        remaining_sel = 2'd1;
        set_dur(1, 7);
        pulse(4'b0010, 4'b0000);
        idle(15);
        chk("busy before async rst", 32'(busy[1]), 1);
        #2;
        reset = 1'b1;
        #1;
        chk("async rst tick", 32'(tick), 0);
        chk("async rst busy", 32'(busy), 0);
        chk("async rst done", 32'(done), 0);
        chk("async rst remaining", 32'(remaining), 0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        model_reset();
        idle(30);

        // Randomized traffic.
        repeat (1500) begin
            for (int ch = 0; ch < 4; ch++) begin
                set_dur(ch, ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 8)));
                start[ch]  = ($urandom_range(0, 11) == 0);
                cancel[ch] = ($urandom_range(0, 29) == 0);
            end
            remaining_sel = 2'($urandom_range(0, 3));
            cycle();
        end
        idle(3);

        @(posedge clock);
        #2;
        chk("scoreboard drained", 32'(q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
